lii_rx_unpack: RTL and testbench

LII_RX_UNPACK -- requirements
Module: lii_rx_unpack

---
 rtl/lii_rx_unpack_if.sv | 26 ++
 rtl/lii_rx_unpack.sv | 117 +++++++++++
 tb/tb_lii_rx_unpack.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/lii_rx_unpack_if.sv
// Handshake bundle between an LII phy-word producer and the element-stream kernel.
// The slave modport is the unpacker's view; the master modport is its environment.
interface lii_rx_unpack_if #(
  parameter int PW = 64,
  parameter int EW = 16
);
  logic [PW-1:0] lii_in_tdata;
  logic          lii_in_tvalid;
  logic          lii_in_tready;
  logic [7:0]    lii_in_src;
  logic [7:0]    lii_in_dst;
  logic [EW-1:0] out_stream_tdata;
  logic          out_stream_tvalid;
  logic          out_stream_tready;
  logic [7:0]    out_stream_src;

  modport master (
    output lii_in_tdata, lii_in_tvalid, lii_in_src, lii_in_dst, out_stream_tready,
    input  lii_in_tready, out_stream_tdata, out_stream_tvalid, out_stream_src
  );

  modport slave (
    input  lii_in_tdata, lii_in_tvalid, lii_in_src, lii_in_dst, out_stream_tready,
    output lii_in_tready, out_stream_tdata, out_stream_tvalid, out_stream_src
  );
endinterface

// File: rtl/lii_rx_unpack.sv
// Unpacks LII phy words addressed to this node into EW-wide elements, lane 0 first,
// and counts words discarded for a destination mismatch.
module lii_rx_unpack #(
  parameter int         PW      = 64,
  parameter int         EW      = 16,
  parameter logic [7:0] NODE_ID = 8'h01
) (
  input  logic               aclk,
  input  logic               arst,
  lii_rx_unpack_if.slave     bus,
  output logic [15:0]        drop_count
);
  localparam int LANES = PW / EW;
  localparam int LW    = $clog2(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_DRAIN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [PW-1:0] data_q, data_d;
  logic [7:0]    src_q, src_d;
  logic [15:0]   drop_q, drop_d;

  logic          last_s;
  logic          in_ready_s;
  logic          out_hs_s;
  logic          in_hs_s;
  logic          match_s;
  logic [EW-1:0] elem_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // Handshake decode; input ready depends only on state and downstream ready.
  always_comb begin
    last_s     = (lane_q == LAST_LANE);
    in_ready_s = 1'b0;
    if (state_q == ST_EMPTY) begin
      in_ready_s = 1'b1;
    end else if (last_s && bus.out_stream_tready) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    out_hs_s = (state_q == ST_DRAIN) && bus.out_stream_tready;
    in_hs_s  = bus.lii_in_tvalid && in_ready_s;
    match_s  = (bus.lii_in_dst == NODE_ID);
  end

  // Next-state: drain handshake first, a newly accepted matching word overrides it.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    data_d  = data_q;
    src_d   = src_q;
    drop_d  = drop_q;
    if (out_hs_s) begin
      if (last_s) begin
        state_d = ST_EMPTY;
        lane_d  = '0;
      end else begin
        lane_d = lane_q + LW'(1);
      end
    end else begin
      lane_d = lane_q;
    end
    if (in_hs_s) begin
      if (match_s) begin
        state_d = ST_DRAIN;
        lane_d  = '0;
        data_d  = bus.lii_in_tdata;
        src_d   = bus.lii_in_src;
      end else begin
        drop_d = sat_inc(drop_q);
      end
    end else begin
      drop_d = drop_q;
    end
  end

  // Lane select from the holding register.
  always_comb begin
    elem_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LW'(i)) begin
        elem_s = data_q[i*EW +: EW];
      end else begin
        elem_s = elem_s;
      end
    end
  end

  // State register; reset also throws away any partially drained word.
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q <= ST_EMPTY;
      lane_q  <= '0;
      data_q  <= '0;
      src_q   <= 8'h00;
      drop_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      src_q   <= src_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.lii_in_tready     = in_ready_s;
  assign bus.out_stream_tvalid = (state_q == ST_DRAIN);
  assign bus.out_stream_tdata  = elem_s;
  assign bus.out_stream_src    = src_q;
  assign drop_count            = drop_q;
endmodule

// File: tb/tb_lii_rx_unpack.sv
// Directed bench for lii_rx_unpack: a per-cycle vector table plus hand-written
// sequences for back-to-back, backpressure, reset mid-drain and counter saturation.
module tb_lii_rx_unpack;
  logic        aclk = 1'b0;
  logic        arst;
  logic [15:0] drop_count;
  int          checks = 0;
  int          errors = 0;

  localparam logic [63:0] WA = 64'h4444_3333_2222_1111;
  localparam logic [63:0] WB = 64'h8888_7777_6666_5555;
  localparam logic [63:0] WC = 64'hCCCC_BBBB_AAAA_9999;

  lii_rx_unpack_if #(.PW(64), .EW(16)) bus ();

  lii_rx_unpack #(.PW(64), .EW(16), .NODE_ID(8'h01)) dut (
    .aclk       (aclk),
    .arst       (arst),
    .bus        (bus),
    .drop_count (drop_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        iv;
    logic [63:0] id;
    logic [7:0]  isrc;
    logic [7:0]  idst;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [15:0] e_od;
    logic [7:0]  e_osrc;
    logic [15:0] e_drop;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(logic iv, logic [63:0] d, logic [7:0] s, logic [7:0] dt,
                              logic ordy, logic irdy, logic ov, logic [15:0] od,
                              logic [7:0] os, logic [15:0] dr);
    vec_t v;
    v.iv = iv; v.id = d; v.isrc = s; v.idst = dt; v.ordy = ordy;
    v.e_irdy = irdy; v.e_ov = ov; v.e_od = od; v.e_osrc = os; v.e_drop = dr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs away from the rising edge, then settle before sampling.
  task automatic step(input logic r, input logic iv, input logic [63:0] d,
                      input logic [7:0] s, input logic [7:0] dt, input logic ordy);
    @(negedge aclk);
    arst                  = r;
    bus.lii_in_tvalid     = iv;
    bus.lii_in_tdata      = d;
    bus.lii_in_src        = s;
    bus.lii_in_dst        = dt;
    bus.out_stream_tready = ordy;
    #1;
  endtask

  task automatic chk_out(input string name, input logic irdy, input logic ov,
                         input logic [15:0] od, input logic [7:0] os);
    chk({name, ".in_tready"}, bus.lii_in_tready, irdy);
    chk({name, ".tvalid"}, bus.out_stream_tvalid, ov);
    if (ov) begin
      chk({name, ".tdata"}, bus.out_stream_tdata, od);
      chk({name, ".src"}, bus.out_stream_src, os);
    end
  endtask

  logic [63:0] ws [3];
  int          acc_cyc [3];
  int          elt_cyc [12];
  int          wi;
  int          ei;

  initial begin
    // Single word, filtering, and both simultaneous-event cases, one row per cycle.
    tbl[0]  = mk(1'b1, WA, 8'h07, 8'h01, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 16'd0);
    tbl[1]  = mk(1'b0, 64'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 16'h1111, 8'h07, 16'd0);
    tbl[2]  = mk(1'b0, 64'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 16'h2222, 8'h07, 16'd0);
    tbl[3]  = mk(1'b0, 64'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 16'h3333, 8'h07, 16'd0);
    tbl[4]  = mk(1'b0, 64'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 16'h4444, 8'h07, 16'd0);
    tbl[5]  = mk(1'b1, WB, 8'h09, 8'h02, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 16'd0);
    tbl[6]  = mk(1'b1, WA, 8'h07, 8'h01, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 16'd1);
    tbl[7]  = mk(1'b1, WC, 8'h0A, 8'h03, 1'b1, 1'b0, 1'b1, 16'h1111, 8'h07, 16'd1);
    tbl[8]  = mk(1'b1, WC, 8'h0A, 8'h03, 1'b1, 1'b0, 1'b1, 16'h2222, 8'h07, 16'd1);
    tbl[9]  = mk(1'b1, WC, 8'h0A, 8'h03, 1'b1, 1'b0, 1'b1, 16'h3333, 8'h07, 16'd1);
    tbl[10] = mk(1'b1, WC, 8'h0A, 8'h03, 1'b1, 1'b1, 1'b1, 16'h4444, 8'h07, 16'd1);
    tbl[11] = mk(1'b0, 64'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 16'd2);
    tbl[12] = mk(1'b1, WB, 8'h05, 8'h01, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 16'd2);
    tbl[13] = mk(1'b1, WC, 8'h06, 8'h01, 1'b1, 1'b0, 1'b1, 16'h5555, 8'h05, 16'd2);
    tbl[14] = mk(1'b1, WC, 8'h06, 8'h01, 1'b1, 1'b0, 1'b1, 16'h6666, 8'h05, 16'd2);
    tbl[15] = mk(1'b1, WC, 8'h06, 8'h01, 1'b1, 1'b0, 1'b1, 16'h7777, 8'h05, 16'd2);
    tbl[16] = mk(1'b1, WC, 8'h06, 8'h01, 1'b1, 1'b1, 1'b1, 16'h8888, 8'h05, 16'd2);
    tbl[17] = mk(1'b0, 64'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 16'h9999, 8'h06, 16'd2);
    tbl[18] = mk(1'b0, 64'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 16'hAAAA, 8'h06, 16'd2);
    tbl[19] = mk(1'b0, 64'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 16'hAAAA, 8'h06, 16'd2);
    tbl[20] = mk(1'b0, 64'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 16'hBBBB, 8'h06, 16'd2);
    tbl[21] = mk(1'b0, 64'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 16'hCCCC, 8'h06, 16'd2);
    tbl[22] = mk(1'b0, 64'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 16'd2);
    ws[0] = WA; ws[1] = WB; ws[2] = WC;

    // Reset with a matching word offered: it must not be captured.
    step(1'b1, 1'b1, WA, 8'h07, 8'h01, 1'b1);
    step(1'b1, 1'b1, WA, 8'h07, 8'h01, 1'b1);
    step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    chk_out("reset", 1'b1, 1'b0, 16'h0000, 8'h00);
    chk("reset.drop", drop_count, 16'd0);

    for (int i = 0; i < 23; i++) begin
      step(1'b0, tbl[i].iv, tbl[i].id, tbl[i].isrc, tbl[i].idst, tbl[i].ordy);
      chk_out($sformatf("vec%0d", i), tbl[i].e_irdy, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_osrc);
      chk($sformatf("vec%0d.drop", i), drop_count, tbl[i].e_drop);
    end

    // Back-to-back: three words with tvalid held, twelve gap-free elements.
    wi = 0;
    ei = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step(1'b0, (wi < 3), ws[(wi < 3) ? wi : 0], 8'h10 + 8'(wi), 8'h01, 1'b1);
      if (bus.out_stream_tvalid && ei < 12) begin
        chk($sformatf("b2b.elem%0d", ei), bus.out_stream_tdata, ws[ei/4][(ei%4)*16 +: 16]);
        chk($sformatf("b2b.src%0d", ei), bus.out_stream_src, 8'h10 + 8'(ei/4));
        elt_cyc[ei] = cyc;
        ei++;
      end
      if (bus.lii_in_tvalid && bus.lii_in_tready && wi < 3) begin
        acc_cyc[wi] = cyc;
        wi++;
      end
    end
    chk("b2b.count", ei, 12);
    chk("b2b.acc_gap1", acc_cyc[1] - acc_cyc[0], 4);
    chk("b2b.acc_gap2", acc_cyc[2] - acc_cyc[1], 4);
    chk("b2b.latency", elt_cyc[0] - acc_cyc[0], 1);
    chk("b2b.span", elt_cyc[11] - elt_cyc[0], 11);

    // Backpressure at lane 2, then a held last lane, then a seamless next word.
    step(1'b0, 1'b1, WA, 8'h07, 8'h01, 1'b1);
    chk_out("bp.accept", 1'b1, 1'b0, 16'h0000, 8'h00);
    step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    chk_out("bp.l0", 1'b0, 1'b1, 16'h1111, 8'h07);
    step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    chk_out("bp.l1", 1'b0, 1'b1, 16'h2222, 8'h07);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, WB, 8'h08, 8'h01, 1'b0);
      chk_out($sformatf("bp.hold%0d", k), 1'b0, 1'b1, 16'h3333, 8'h07);
    end
    step(1'b0, 1'b1, WB, 8'h08, 8'h01, 1'b1);
    chk_out("bp.l2", 1'b0, 1'b1, 16'h3333, 8'h07);
    step(1'b0, 1'b1, WB, 8'h08, 8'h01, 1'b0);
    chk_out("bp.l3hold", 1'b0, 1'b1, 16'h4444, 8'h07);
    step(1'b0, 1'b1, WB, 8'h08, 8'h01, 1'b1);
    chk_out("bp.l3", 1'b1, 1'b1, 16'h4444, 8'h07);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
      chk_out($sformatf("bp.next%0d", k), (k == 3), 1'b1, WB[k*16 +: 16], 8'h08);
    end
    step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    chk_out("bp.idle", 1'b1, 1'b0, 16'h0000, 8'h00);

    // Reset right after the lane-1 handshake; remaining lanes must vanish.
    step(1'b0, 1'b1, WA, 8'h07, 8'h01, 1'b1);
    step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    chk_out("rmd.l1", 1'b0, 1'b1, 16'h2222, 8'h07);
    chk("rmd.drop_before", drop_count, 16'd2);
    step(1'b1, 1'b1, WB, 8'h08, 8'h01, 1'b1);
    step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    chk_out("rmd.after", 1'b1, 1'b0, 16'h0000, 8'h00);
    chk("rmd.drop", drop_count, 16'd0);
    step(1'b0, 1'b1, WC, 8'h0B, 8'h01, 1'b1);
    step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    chk_out("rmd.new_l0", 1'b0, 1'b1, 16'h9999, 8'h0B);
    step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    chk_out("rmd.new_l1", 1'b0, 1'b1, 16'hAAAA, 8'h0B);
    step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    chk_out("rmd.idle", 1'b1, 1'b0, 16'h0000, 8'h00);

    // 65536 consecutive mismatches from a cleared counter.
    step(1'b1, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    for (int k = 0; k < 65534; k++) begin
      step(1'b0, 1'b1, WA, 8'h07, 8'hFF, 1'b1);
    end
    step(1'b0, 1'b1, WA, 8'h07, 8'hFF, 1'b1);
    chk("sat.fffe", drop_count, 16'hFFFE);
    step(1'b0, 1'b1, WA, 8'h07, 8'hFF, 1'b1);
    chk("sat.ffff", drop_count, 16'hFFFF);
    step(1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b1);
    chk("sat.hold", drop_count, 16'hFFFF);
    chk_out("sat.idle", 1'b1, 1'b0, 16'h0000, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
